part5_19: RTL and testbench
===========================

PART5_19 -- requirements
Module: part5_19

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Parameter OPERAND_A, default 8'hA5 (WIDTH bits), first addend.
REQ-003 Parameter OPERAND_B, default 8'h3C (WIDTH bits), second addend.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 clear  input  1  reset, synchronous and active-high.
REQ-006 final_out_sum  output  1  registered sum bit of the current serial-add step.
REQ-007 final_out_carry  output  1  registered carry-out of the current serial-add step.

Function
REQ-008 The block SHALL be a self-stimulating, LSB-first bit-serial adder: each add pass adds OPERAND_A + OPERAND_B over WIDTH consecutive clock cycles.
REQ-009 Internal state SHALL be: bit index k (0..WIDTH-1), carry register c, operand shift registers sa/sb (WIDTH bits each), and output registers for sum and carry.
REQ-010 Each rising edge with clear=0 SHALL compute the full-adder result of a=sa[0], b=sb[0], cin=c: s = a^b^cin, co = (a&b)|(a&cin)|(b&cin).
REQ-011 On the same edge, final_out_sum SHALL take s and final_out_carry SHALL take co; outputs change only at clock edges (no combinational path to outputs).
REQ-012 If k < WIDTH-1, then sa and sb SHALL shift right by one, c SHALL take co, and k SHALL increment.
REQ-013 If k = WIDTH-1 (last bit), then sa and sb SHALL reload OPERAND_A and OPERAND_B, c SHALL clear to 0, and k SHALL wrap to 0; passes repeat indefinitely with no idle cycle between them.
REQ-014 Latency: bit i of a pass SHALL appear on the outputs after the (i+1)-th edge of that pass; the final carry-out (overflow) of the pass SHALL be final_out_carry during the cycle after bit WIDTH-1 is computed.
REQ-015 Over a pass, the WIDTH sum bits collected LSB first SHALL equal (OPERAND_A + OPERAND_B) mod 2^WIDTH, and the last carry bit SHALL equal bit WIDTH of the true sum.

Reset
REQ-016 On a rising edge with clear=1: final_out_sum=0, final_out_carry=0, c=0, k=0, sa=OPERAND_A, sb=OPERAND_B.
REQ-017 clear SHALL take priority over all other updates, including when asserted in the middle of a pass; that pass is abandoned.
REQ-018 After clear deasserts, the first edge with clear=0 SHALL process bit 0 of a fresh pass.
REQ-019 Holding clear high for several cycles SHALL keep all outputs at 0.
REQ-020 Before the first clear, output values are undefined; the bench SHALL assert clear first.

Verification
REQ-021 Defaults, 10 ns clock, clear=1 for 2 edges then 0 -> sum sequence over edges 1..8: 1,0,0,0,0,1,1,1 (0xE1); carry sequence: 0,0,1,1,1,1,0,0.
REQ-022 Defaults, run 3 passes -> the sum and carry sequences of REQ-021 repeat exactly every 8 cycles, with no gap between passes.
REQ-023 OPERAND_A=8'hFF, OPERAND_B=8'h01 -> sum bits are all 0 and carry bits are all 1 over the pass; the final carry is 1 (overflow).
REQ-024 Defaults, assert clear for one edge at bit index 3 -> outputs are 0/0 after that edge, and the next edges reproduce REQ-021 starting from bit 0.
REQ-025 OPERAND_A=0, OPERAND_B=0 -> both outputs stay 0 indefinitely after reset.
REQ-026 WIDTH=4, OPERAND_A=4'h9, OPERAND_B=4'h7 -> sum bits LSB first 0,0,0,0 and carry bits 1,1,1,1 (sum 0x10), repeating every 4 cycles.

Source files
------------

// File: rtl/part5_19.sv
// Self-stimulating LSB-first bit-serial adder: OPERAND_A + OPERAND_B, one bit per clock, passes back to back.
// Bit i of a pass is registered on the (i+1)-th edge of that pass; no flow control, output every cycle.
module part5_19 #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] OPERAND_A = WIDTH'(8'hA5),
  parameter logic [WIDTH-1:0] OPERAND_B = WIDTH'(8'h3C)
) (
  input  logic clock,
  input  logic clear,
  output logic final_out_sum,
  output logic final_out_carry
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] KLAST = KW'(WIDTH - 1);

  logic [KW-1:0]    k;
  logic             c;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic             s;
  logic             co;

  always_comb begin
    s  = sa[0] ^ sb[0] ^ c;
    co = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      final_out_sum   <= 1'b0;
      final_out_carry <= 1'b0;
      c               <= 1'b0;
      k               <= '0;
      sa              <= OPERAND_A;
      sb              <= OPERAND_B;
    end else begin
      final_out_sum   <= s;
      final_out_carry <= co;
      // Last bit of the pass: reload operands so the next pass starts with no idle cycle.
      if (k == KLAST) begin
        sa <= OPERAND_A;
        sb <= OPERAND_B;
        c  <= 1'b0;
        k  <= '0;
      end else begin
        sa <= {1'b0, sa[WIDTH-1:1]};
        sb <= {1'b0, sb[WIDTH-1:1]};
        c  <= co;
        k  <= k + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_part5_19.sv
// Scoreboard bench for part5_19: four parameterisations share one clear stream; expectations come from whole-number addition.
module tb_part5_19;

  logic clk;
  logic clear;
  logic [3:0] sum_o;
  logic [3:0] car_o;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  part5_19 #(.WIDTH(8), .OPERAND_A(8'hA5), .OPERAND_B(8'h3C)) u_def (
    .clock(clk), .clear(clear), .final_out_sum(sum_o[0]), .final_out_carry(car_o[0]));
  part5_19 #(.WIDTH(8), .OPERAND_A(8'hFF), .OPERAND_B(8'h01)) u_ovf (
    .clock(clk), .clear(clear), .final_out_sum(sum_o[1]), .final_out_carry(car_o[1]));
  part5_19 #(.WIDTH(8), .OPERAND_A(8'h00), .OPERAND_B(8'h00)) u_zero (
    .clock(clk), .clear(clear), .final_out_sum(sum_o[2]), .final_out_carry(car_o[2]));
  part5_19 #(.WIDTH(4), .OPERAND_A(4'h9), .OPERAND_B(4'h7)) u_w4 (
    .clock(clk), .clear(clear), .final_out_sum(sum_o[3]), .final_out_carry(car_o[3]));

  int          wv [4] = '{8, 8, 8, 4};
  int unsigned av [4] = '{32'hA5, 32'hFF, 32'h00, 32'h9};
  int unsigned bv [4] = '{32'h3C, 32'h01, 32'h00, 32'h7};
  int          pos [4] = '{0, 0, 0, 0};

  logic [7:0] sbq [$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Sum bit i and carry out of bit i, from adding the low i+1 bits of each operand.
  function automatic logic [1:0] ref_bits(input int unsigned a, input int unsigned b, input int i);
    longint unsigned m;
    longint unsigned t;
    m = (64'd1 << (i + 1)) - 64'd1;
    t = (longint'(a) & m) + (longint'(b) & m);
    return {t[i], t[i + 1]};
  endfunction

  // Drive clear for the coming edge and record what every instance must show after it.
  task automatic step(input logic clr);
    logic [7:0] e;
    e = '0;
    for (int n = 0; n < 4; n++) begin
      if (clr) begin
        e[2*n +: 2] = 2'b00;
        pos[n] = 0;
      end else begin
        e[2*n +: 2] = ref_bits(av[n], bv[n], pos[n]);
        pos[n] = (pos[n] + 1) % wv[n];
      end
    end
    clear = clr;
    sbq.push_back(e);
  endtask

  initial begin
    logic [7:0] e;
    logic [7:0] act;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        for (int n = 0; n < 4; n++) begin
          act[2*n +: 2] = {sum_o[n], car_o[n]};
          total++;
          if (act[2*n +: 2] !== e[2*n +: 2]) begin
            bad++;
            $display("FAIL inst%0d cycle %0d sum/carry got=%b want=%b", n, cyc, act[2*n +: 2], e[2*n +: 2]);
          end
        end
      end
    end
  end

  initial begin
    step(1'b1);
    @(negedge clk);
    step(1'b1);
    @(negedge clk);
    repeat (24) begin
      step(1'b0);
      @(negedge clk);
    end
    // Abandon a pass at bit index 3, then run on.
    repeat (3) begin
      step(1'b0);
      @(negedge clk);
    end
    step(1'b1);
    @(negedge clk);
    repeat (10) begin
      step(1'b0);
      @(negedge clk);
    end
    repeat (3) begin
      step(1'b1);
      @(negedge clk);
    end
    repeat (400) begin
      step($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain leftover=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
